// File: rtl/atmo_light_est.sv
// -----------------------------------------------------------------------------
// atmo_light_est -- streaming atmospheric-light estimator.
//
// Takes one RGB window (TAPS taps per channel) per cycle and computes its
// dark channel, the minimum over every tap of every channel. Across a frame
// it keeps the window with the largest dark channel. At end of frame it
// publishes that window's per-channel minima as the atmospheric light A.
// A is held until the next frame completes.
//
// Pipeline:
//   stage 1  per-channel tap minimum (mr, mg, mb)
//   stage 2  dark = min(mr, mg, mb)
//   stage 3  running-best update and publish on eof
//
// Optional feature macro: ATMO_SUM_TIEBREAK_EN
//   defined   - when two windows have equal dark values, the window with the
//               larger mr+mg+mb wins. Equal sums keep the earlier window.
//   undefined - ties always keep the earlier window.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   in_valid             window on win_* is valid this cycle
//   in_sof / in_eof      first / last window of frame (qualified by in_valid)
//   win_r/win_g/win_b    TAPS*DW bits each; tap k is at [k*DW +: DW]
//   a_r/a_g/a_b          atmospheric light of the last completed frame
//   a_dark               dark-channel value of the selected window
//   a_valid              one-cycle pulse when a_* update
//   frame_err            one-cycle pulse on a framing violation
//   busy                 a frame is open or the pipeline holds valid data
// -----------------------------------------------------------------------------
module atmo_light_est #(
    parameter int DW   = 8,
    parameter int TAPS = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_eof,
    input  logic [TAPS*DW-1:0] win_r,
    input  logic [TAPS*DW-1:0] win_g,
    input  logic [TAPS*DW-1:0] win_b,
    output logic [DW-1:0]      a_r,
    output logic [DW-1:0]      a_g,
    output logic [DW-1:0]      a_b,
    output logic [DW-1:0]      a_dark,
    output logic               a_valid,
    output logic               frame_err,
    output logic               busy
);

    function automatic logic [DW-1:0] chan_min(input logic [TAPS*DW-1:0] v);
        logic [DW-1:0] m;
        m = v[DW-1:0];
        for (int k = 1; k < TAPS; k++) begin
            if (v[k*DW +: DW] < m) m = v[k*DW +: DW];
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] x,
                                           input logic [DW-1:0] y,
                                           input logic [DW-1:0] z);
        logic [DW-1:0] m;
        m = (x < y) ? x : y;
        return (z < m) ? z : m;
    endfunction

    // ---------------- stage 1: per-channel minima ----------------
    logic          s1_valid_q, s1_sof_q, s1_eof_q;
    logic [DW-1:0] s1_mr_q, s1_mg_q, s1_mb_q;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of its source; blocking here would
    // collapse pipeline stages in simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_mr_q    <= '0;
            s1_mg_q    <= '0;
            s1_mb_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_valid & in_sof;
            s1_eof_q   <= in_valid & in_eof;
            // Bubbles leave the data registers untouched.
            if (in_valid) begin
                s1_mr_q <= chan_min(win_r);
                s1_mg_q <= chan_min(win_g);
                s1_mb_q <= chan_min(win_b);
            end
        end
    end

    // ---------------- stage 2: dark channel ----------------
    logic          s2_valid_q, s2_sof_q, s2_eof_q;
    logic [DW-1:0] s2_mr_q, s2_mg_q, s2_mb_q, s2_dark_q;
`ifdef ATMO_SUM_TIEBREAK_EN
    logic [DW+1:0] s2_sum_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
            s2_mr_q    <= '0;
            s2_mg_q    <= '0;
            s2_mb_q    <= '0;
            s2_dark_q  <= '0;
`ifdef ATMO_SUM_TIEBREAK_EN
            s2_sum_q   <= '0;
`endif
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            s2_eof_q   <= s1_eof_q;
            if (s1_valid_q) begin
                s2_mr_q   <= s1_mr_q;
                s2_mg_q   <= s1_mg_q;
                s2_mb_q   <= s1_mb_q;
                s2_dark_q <= min3(s1_mr_q, s1_mg_q, s1_mb_q);
`ifdef ATMO_SUM_TIEBREAK_EN
                s2_sum_q  <= {2'b00, s1_mr_q} + {2'b00, s1_mg_q} + {2'b00, s1_mb_q};
`endif
            end
        end
    end

    // ---------------- stage 3: running best and publish ----------------
    logic          frame_open_q, frame_open_d;
    logic [DW-1:0] best_r_q, best_g_q, best_b_q, best_dark_q;
    logic [DW-1:0] best_r_d, best_g_d, best_b_d, best_dark_d;
    logic [DW-1:0] a_r_q, a_g_q, a_b_q, a_dark_q;
    logic [DW-1:0] a_r_d, a_g_d, a_b_d, a_dark_d;
    logic          a_valid_q, a_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          win_better, take;
`ifdef ATMO_SUM_TIEBREAK_EN
    logic [DW+1:0] best_sum_q, best_sum_d;
`endif

    // NOTE: every variable assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        frame_open_d = frame_open_q;
        best_r_d     = best_r_q;
        best_g_d     = best_g_q;
        best_b_d     = best_b_q;
        best_dark_d  = best_dark_q;
        a_r_d        = a_r_q;
        a_g_d        = a_g_q;
        a_b_d        = a_b_q;
        a_dark_d     = a_dark_q;
        a_valid_d    = 1'b0;
        frame_err_d  = 1'b0;
        take         = 1'b0;
`ifdef ATMO_SUM_TIEBREAK_EN
        best_sum_d   = best_sum_q;
        win_better   = (s2_dark_q > best_dark_q) ||
                       ((s2_dark_q == best_dark_q) && (s2_sum_q > best_sum_q));
`else
        // Strict compare: ties keep the earlier window.
        win_better   = (s2_dark_q > best_dark_q);
`endif

        if (s2_valid_q) begin
            if (s2_sof_q) begin
                // sof restarts unconditionally; an open frame is discarded.
                frame_err_d = frame_open_q;
                take        = 1'b1;
            end else if (frame_open_q) begin
                take        = win_better;
            end else begin
                // Window (with or without eof) outside any frame: ignored.
                frame_err_d = 1'b1;
            end

            if (s2_sof_q || frame_open_q) begin
                if (take) begin
                    best_r_d    = s2_mr_q;
                    best_g_d    = s2_mg_q;
                    best_b_d    = s2_mb_q;
                    best_dark_d = s2_dark_q;
`ifdef ATMO_SUM_TIEBREAK_EN
                    best_sum_d  = s2_sum_q;
`endif
                end
                frame_open_d = !s2_eof_q;
                if (s2_eof_q) begin
                    // Publish the best including this window.
                    a_r_d     = best_r_d;
                    a_g_d     = best_g_d;
                    a_b_d     = best_b_d;
                    a_dark_d  = best_dark_d;
                    a_valid_d = 1'b1;
                end
            end
        end
    end

    // The best registers are reset too: a reset mid-frame must leave no
    // trace of the aborted frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_open_q <= 1'b0;
            best_r_q     <= '0;
            best_g_q     <= '0;
            best_b_q     <= '0;
            best_dark_q  <= '0;
            a_r_q        <= '0;
            a_g_q        <= '0;
            a_b_q        <= '0;
            a_dark_q     <= '0;
            a_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef ATMO_SUM_TIEBREAK_EN
            best_sum_q   <= '0;
`endif
        end else begin
            frame_open_q <= frame_open_d;
            best_r_q     <= best_r_d;
            best_g_q     <= best_g_d;
            best_b_q     <= best_b_d;
            best_dark_q  <= best_dark_d;
            a_r_q        <= a_r_d;
            a_g_q        <= a_g_d;
            a_b_q        <= a_b_d;
            a_dark_q     <= a_dark_d;
            a_valid_q    <= a_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef ATMO_SUM_TIEBREAK_EN
            best_sum_q   <= best_sum_d;
`endif
        end
    end

    assign a_r       = a_r_q;
    assign a_g       = a_g_q;
    assign a_b       = a_b_q;
    assign a_dark    = a_dark_q;
    assign a_valid   = a_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = frame_open_q | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_atmo_light_est.sv
// -----------------------------------------------------------------------------
// tb_atmo_light_est -- directed self-checking bench for atmo_light_est
// (DW=8, TAPS=9). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_atmo_light_est;
    localparam int DW   = 8;
    localparam int TAPS = 9;

    logic               clk;
    logic               reset;
    logic               in_valid, in_sof, in_eof;
    logic [TAPS*DW-1:0] win_r, win_g, win_b;
    logic [DW-1:0]      a_r, a_g, a_b, a_dark;
    logic               a_valid, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic [31:0] aq[$];

    atmo_light_est #(.DW(DW), .TAPS(TAPS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .win_r(win_r), .win_g(win_g), .win_b(win_b),
        .a_r(a_r), .a_g(a_g), .a_b(a_b), .a_dark(a_dark),
        .a_valid(a_valid), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every publish and every framing error, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_valid) aq.push_back({a_r, a_g, a_b, a_dark});
        if (frame_err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_raw(input logic [TAPS*DW-1:0] r, g, b, input logic sof, eof);
        in_valid = 1'b1; in_sof = sof; in_eof = eof;
        win_r = r; win_g = g; win_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    task automatic send(input logic [7:0] r, g, b, input logic sof, eof);
        send_raw({TAPS{r}}, {TAPS{g}}, {TAPS{b}}, sof, eof);
    endtask

    // Called right after the eof acceptance edge; returns edges until a_valid.
    task automatic wait_aval(output int lat);
        lat = 0;
        while (a_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== 32'h0) begin
            errors++; $display("FAIL reset_a: got %h want 00000000", {a_r, a_g, a_b, a_dark});
        end
        checks++;
        if ({a_valid, frame_err, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {a_valid, frame_err, busy});
        end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] held;
        aq.delete(); err_cnt = 0;
        send(10, 20, 30, 1, 0);
        send(50, 60, 40, 0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b want 1", busy);
        end
        send(90, 90, 90, 0, 0);
        send(70, 80, 75, 0, 1);
        wait_aval(lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL basic_latency: got %0d edges want 2 (3 cycles)", lat);
        end
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== {8'd90, 8'd90, 8'd90, 8'd90}) begin
            errors++; $display("FAIL basic_a: got %h want 5a5a5a5a", {a_r, a_g, a_b, a_dark});
        end
        held = {a_r, a_g, a_b, a_dark};
        idle(1);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: a_valid got %b want 0", a_valid);
        end
        idle(4);
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== held || busy !== 1'b0) begin
            errors++; $display("FAIL basic_hold: got %h busy %b want %h busy 0",
                               {a_r, a_g, a_b, a_dark}, busy, held);
        end
        checks++;
        if (aq.size() !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL basic_counts: pubs %0d errs %0d want 1 0", aq.size(), err_cnt);
        end
    endtask

    task automatic test_min_tap();
        logic [TAPS*DW-1:0] g;
        g = {TAPS{8'd200}};
        g[4*DW +: DW] = 8'd5;
        aq.delete();
        send_raw({TAPS{8'd200}}, g, {TAPS{8'd200}}, 1, 1);
        idle(4);
        checks++;
        if (aq.size() !== 1 || {a_r, a_g, a_b, a_dark} !== {8'd200, 8'd5, 8'd200, 8'd5}) begin
            errors++; $display("FAIL min_tap: got %h pubs %0d want c805c805 pubs 1",
                               {a_r, a_g, a_b, a_dark}, aq.size());
        end
    endtask

    task automatic test_tie();
        logic [31:0] exp_a;
`ifdef ATMO_SUM_TIEBREAK_EN
        exp_a = {8'd40, 8'd90, 8'd90, 8'd40};
`else
        exp_a = {8'd40, 8'd80, 8'd80, 8'd40};
`endif
        aq.delete();
        send(40, 80, 80, 1, 0);
        send(40, 90, 90, 0, 1);
        idle(4);
        checks++;
        if (aq.size() !== 1 || {a_r, a_g, a_b, a_dark} !== exp_a) begin
            errors++; $display("FAIL tie: got %h pubs %0d want %h pubs 1",
                               {a_r, a_g, a_b, a_dark}, aq.size(), exp_a);
        end
    endtask

    task automatic test_bubbles();
        int lat;
        aq.delete();
        send(10, 20, 30, 1, 0); idle(1);
        send(50, 60, 40, 0, 0); idle(1);
        send(90, 90, 90, 0, 0); idle(1);
        send(70, 80, 75, 0, 1);
        wait_aval(lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL bubbles_latency: got %0d edges want 2", lat);
        end
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== {8'd90, 8'd90, 8'd90, 8'd90}) begin
            errors++; $display("FAIL bubbles_a: got %h want 5a5a5a5a", {a_r, a_g, a_b, a_dark});
        end
        idle(3);
    endtask

    task automatic test_framing();
        // sof restart inside an open frame
        aq.delete(); err_cnt = 0;
        send(100, 100, 100, 1, 0);
        send(110, 110, 110, 0, 0);
        send(20, 30, 40, 1, 0);
        send(25, 25, 25, 0, 1);
        idle(5);
        checks++;
        if (err_cnt !== 1 || aq.size() !== 1) begin
            errors++; $display("FAIL restart_counts: errs %0d pubs %0d want 1 1", err_cnt, aq.size());
        end
        checks++;
        if ({a_r, a_g, a_b, a_dark} !== {8'd25, 8'd25, 8'd25, 8'd25}) begin
            errors++; $display("FAIL restart_a: got %h want 19191919", {a_r, a_g, a_b, a_dark});
        end
        // stray window and stray eof after reset
        pulse_reset();
        aq.delete(); err_cnt = 0;
        send(70, 70, 70, 0, 0);
        idle(4);
        checks++;
        if (err_cnt !== 1 || aq.size() !== 0 || {a_r, a_g, a_b, a_dark} !== 32'h0) begin
            errors++; $display("FAIL stray_win: errs %0d pubs %0d a %h want 1 0 00000000",
                               err_cnt, aq.size(), {a_r, a_g, a_b, a_dark});
        end
        send(60, 60, 60, 0, 1);
        idle(4);
        checks++;
        if (err_cnt !== 2 || aq.size() !== 0 || {a_r, a_g, a_b, a_dark} !== 32'h0) begin
            errors++; $display("FAIL stray_eof: errs %0d pubs %0d a %h want 2 0 00000000",
                               err_cnt, aq.size(), {a_r, a_g, a_b, a_dark});
        end
    endtask

    task automatic test_reset_mid();
        aq.delete(); err_cnt = 0;
        send(200, 200, 200, 1, 0);
        send(150, 150, 150, 0, 0);
        send(180, 180, 180, 0, 0);
        reset = 1'b0;
        #2;
        checks++;
        if ({a_r, a_g, a_b, a_dark, a_valid, frame_err, busy} !== 35'h0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h %b%b%b want all 0",
                               {a_r, a_g, a_b, a_dark}, a_valid, frame_err, busy);
        end
        idle(3);
        reset = 1'b1;
        idle(1);
        send(30, 40, 50, 1, 0);
        send(60, 60, 60, 0, 1);
        idle(5);
        checks++;
        if (aq.size() !== 1 || err_cnt !== 0 ||
            {a_r, a_g, a_b, a_dark} !== {8'd60, 8'd60, 8'd60, 8'd60}) begin
            errors++; $display("FAIL reset_mid_recover: got %h pubs %0d errs %0d want 3c3c3c3c 1 0",
                               {a_r, a_g, a_b, a_dark}, aq.size(), err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        aq.delete(); err_cnt = 0;
        send(50, 50, 50, 1, 1);
        send(10, 10, 10, 1, 0);
        send(12, 12, 12, 0, 1);
        idle(6);
        checks++;
        if (aq.size() !== 2 || err_cnt !== 0) begin
            errors++; $display("FAIL b2b_counts: pubs %0d errs %0d want 2 0", aq.size(), err_cnt);
        end else begin
            checks++;
            if (aq[0] !== {8'd50, 8'd50, 8'd50, 8'd50}) begin
                errors++; $display("FAIL b2b_first: got %h want 32323232", aq[0]);
            end
            checks++;
            if (aq[1] !== {8'd12, 8'd12, 8'd12, 8'd12}) begin
                errors++; $display("FAIL b2b_second: got %h want 0c0c0c0c", aq[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        win_r = '0; win_g = '0; win_b = '0;
        test_reset();
        test_basic();
        test_min_tap();
        test_tie();
        test_bubbles();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/atmo_light_est.md
# atmo_light_est

Streaming atmospheric-light estimator for the dehaze pipeline. It accepts one 3x3-style RGB window per cycle with a valid qualifier and frame markers. For each window it computes the dark-channel value: the minimum over all taps of all three channels. Across a frame it tracks the window with the largest dark channel, and at end of frame it publishes that window's per-channel minima as the atmospheric light A, held stable until the next frame completes.

## Interface
Parameters:
- DW, 8, pixel component width in bits.
- TAPS, 9, window taps per channel (1..25).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  window on win_* is valid this cycle.
- in_sof  input  1  first window of frame; qualified by in_valid.
- in_eof  input  1  last window of frame; qualified by in_valid.
- win_r, win_g, win_b  input  TAPS*DW  tap k at bits [k*DW +: DW].
- a_r, a_g, a_b  output  DW  atmospheric light of last completed frame.
- a_dark  output  DW  dark-channel value of the selected window.
- a_valid  output  1  one-cycle pulse when a_* update.
- frame_err  output  1  one-cycle pulse on a framing violation.
- busy  output  1  a frame is open or the pipeline holds valid data.

## Operation
- Stage 1 (registered): per-channel minimum over TAPS taps, giving mr, mg, mb; valid, sof and eof flags pipelined alongside.
- Stage 2 (registered): dark = min(mr, mg, mb); mr/mg/mb and the flags forwarded.
- Stage 3 (registered): running-best update.
  - On sof: best is loaded unconditionally from this window; the frame is marked open.
  - Otherwise, with the frame open: best is replaced only if dark > best_dark (strict). Ties keep the earlier window.
  - On eof: the final best, including this window, is copied to a_* and a_dark, and a_valid pulses.
  - sof and eof on the same window: a one-window frame; A is that window.
- Comparisons are unsigned. There is no arithmetic widening except the tie-break sum (see Configuration).
- Bubbles (in_valid=0) carry no state change through any stage.
- Framing violations: frame_err pulses at stage 3 in each case below.
  - sof while a frame is open: the old frame is discarded without a_valid, and the new frame starts.
  - A valid window with no open frame and no sof: the window is ignored.
  - eof with no open frame and no sof: ignored, with no a_valid.
- a_* hold their value between a_valid pulses.
- busy = frame open OR any stage valid.

## Timing
- Throughput: one window per cycle, no backpressure.
- Latency: the eof window accepted in cycle N produces a_valid high in cycle N+3, and a_* are valid that cycle.
- Reset values: a_r, a_g, a_b and a_dark are 0; a_valid, frame_err and busy are 0; the pipeline is empty and no frame is open.
- Reset asserted mid-frame clears everything above immediately (asynchronous). The interrupted frame never produces a_valid, and the first window after release must carry sof.
- Back-to-back frames: eof in cycle N and sof in cycle N+1 are legal. The new frame's best register does not disturb a_* published at N+3.

## Configuration
- ATMO_SUM_TIEBREAK_EN
  - Defined: when dark == best_dark, the window with the larger mr+mg+mb wins. The sum is computed at DW+2 bits in stage 2. Equal sums keep the earlier window.
  - Undefined: the sum logic is absent and strict first-wins tie handling applies.

## Test plan
- Single frame of 4 windows (DW=8, TAPS=9), each with all taps equal, per-channel (r,g,b) values: (10,20,30), (50,60,40), (90,90,90), (70,80,75) -> a_r/a_g/a_b = 90/90/90, a_dark = 90, a_valid exactly 3 cycles after eof.
- Window where tap 4 of green = 5 and all other taps = 200, sent as a one-window frame (sof=eof=1) -> a_dark = 5, a_r = 200, a_g = 5, a_b = 200.
- Tie: the (40,80,80) window then the (40,90,90) window, both dark = 40 -> without the macro A = 40/80/80; with ATMO_SUM_TIEBREAK_EN, A = 40/90/90.
- Bubbles: frame with in_valid low on alternating cycles -> same A as the gap-free run; a_valid 3 cycles after the eof acceptance cycle.
- Framing: sof, 2 windows, then sof again without eof -> frame_err pulses once, and A comes only from the second frame. A valid window with no sof after reset -> frame_err, a_* stay 0.
- Reset mid-frame after 3 windows -> all outputs 0 during reset. A new full frame after release yields the correct A, with no stale best from the aborted frame.
